// File: rtl/sword_anim_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | sword_anim_ctrl_pkg : shared types and ROM address layout for sword anim   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package sword_anim_ctrl_pkg;

  localparam int c_coord_w = 10;
  localparam int c_dir_w   = 2;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COOLDOWN = 2'd2
  } anim_state_t;

  localparam int c_num_frames_def = 4;
  localparam int c_spr_dim_def    = 32;

  // Default address layout: {dir, frame, dy, dx}, dx in the LSBs.
  localparam int c_frame_w    = $clog2(c_num_frames_def);
  localparam int c_pix_w      = $clog2(c_spr_dim_def);
  localparam int c_dx_ofs     = 0;
  localparam int c_dy_ofs     = c_pix_w;
  localparam int c_frame_ofs  = 2 * c_pix_w;
  localparam int c_dir_ofs    = c_frame_ofs + c_frame_w;
  localparam int c_rom_addr_w = c_dir_ofs + c_dir_w;

  function automatic int rom_addr_w(input int num_frames, input int spr_dim);
    return c_dir_w + $clog2(num_frames) + 2 * $clog2(spr_dim);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sword_anim_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | sword_anim_ctrl_if : game-logic <-> sword animation control handshake      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sword_anim_ctrl_if
  import sword_anim_ctrl_pkg::*;
#(
  parameter int FRAME_W = c_frame_w
);

  logic               attack_req;
  logic [c_dir_w-1:0] dir_in;
  logic [FRAME_W-1:0] frame_idx;
  logic               busy;
  logic               done;

  modport master (
    output attack_req, dir_in,
    input  frame_idx, busy, done
  );

  modport slave (
    input  attack_req, dir_in,
    output frame_idx, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/sword_anim_ctrl_frame_tick_gen.sv
// +----------------------------------------------------------------------------+
// | sword_anim_ctrl_frame_tick_gen : one-cycle tick on vsync rising edge       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sword_anim_ctrl_frame_tick_gen (
  input  logic vga_clk,
  input  logic Reset_n,
  input  logic vsync,
  output logic tick
);

  logic r_vsync_q;

  // History resets high so releasing reset with vsync high is not an edge.
  always_ff @(posedge vga_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vsync_q <= 1'b1;
    end else begin
      r_vsync_q <= vsync;
    end
  end

  assign tick = !r_vsync_q && vsync;

endmodule

`default_nettype wire

// File: rtl/sword_anim_ctrl.sv
// +----------------------------------------------------------------------------+
// | sword_anim_ctrl : sword-attack animation sequencer and sprite ROM address  |
// | Optional macro SWORD_MIRROR_EN: left facing reuses the right ROM slice.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sword_anim_ctrl
  import sword_anim_ctrl_pkg::*;
#(
  parameter int NUM_FRAMES     = c_num_frames_def,
  parameter int FRAME_HOLD     = 6,
  parameter int COOLDOWN_TICKS = 8,
  parameter int SPR_DIM        = c_spr_dim_def
) (
  input  logic                                      vga_clk,
  input  logic                                      Reset_n,
  input  logic                                      vsync,
  sword_anim_ctrl_if.slave                          game,
  input  logic [c_coord_w-1:0]                      sprite_x,
  input  logic [c_coord_w-1:0]                      sprite_y,
  input  logic [c_coord_w-1:0]                      DrawX,
  input  logic [c_coord_w-1:0]                      DrawY,
  output logic [rom_addr_w(NUM_FRAMES, SPR_DIM)-1:0] rom_address,
  output logic                                      sprite_on
);

  localparam int c_fr_w   = $clog2(NUM_FRAMES);
  localparam int c_px_w   = $clog2(SPR_DIM);
  localparam int c_hold_w = $clog2(FRAME_HOLD + 1);
  localparam int c_cd_w   = $clog2(COOLDOWN_TICKS + 1);

  localparam logic [c_fr_w-1:0]    c_frame_last = c_fr_w'(NUM_FRAMES - 1);
  localparam logic [c_hold_w-1:0]  c_hold_last  = c_hold_w'(FRAME_HOLD - 1);
  localparam logic [c_cd_w-1:0]    c_cd_last    = c_cd_w'(COOLDOWN_TICKS - 1);
  localparam logic [c_coord_w-1:0] c_spr_dim    = c_coord_w'(SPR_DIM);

  anim_state_t         r_state;
  dir_t                r_dir;
  logic [c_fr_w-1:0]   r_frame;
  logic [c_hold_w-1:0] r_hold;
  logic [c_cd_w-1:0]   r_cd;
  logic                r_done;
  logic                r_on_q1;
  logic                w_tick;

  sword_anim_ctrl_frame_tick_gen u_tick (
    .vga_clk (vga_clk),
    .Reset_n (Reset_n),
    .vsync   (vsync),
    .tick    (w_tick)
  );

  always_ff @(posedge vga_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_dir   <= DIR_UP;
      r_frame <= '0;
      r_hold  <= '0;
      r_cd    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (game.attack_req) begin
            r_state <= ACTIVE;
            r_dir   <= dir_t'(game.dir_in);
            r_frame <= '0;
            r_hold  <= '0;
          end
        end
        ACTIVE: begin
          if (w_tick) begin
            if (r_hold == c_hold_last) begin
              r_hold <= '0;
              if (r_frame == c_frame_last) begin
                r_done  <= 1'b1;
                r_state <= COOLDOWN;
                r_cd    <= '0;
              end else begin
                r_frame <= r_frame + 1'b1;
              end
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
        end
        COOLDOWN: begin
          if (w_tick) begin
            if (r_cd == c_cd_last) begin
              r_state <= IDLE;
            end else begin
              r_cd <= r_cd + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign game.frame_idx = r_frame;
  assign game.busy      = (r_state != IDLE);
  assign game.done      = r_done;

  // Unsigned wrap: pixels left of / above the box become huge and fail the test.
  logic [c_coord_w-1:0] w_dx;
  logic [c_coord_w-1:0] w_dy;
  logic                 w_in_box;
  dir_t                 w_dir_field;
  logic [c_px_w-1:0]    w_dx_field;

  assign w_dx     = DrawX - sprite_x;
  assign w_dy     = DrawY - sprite_y;
  assign w_in_box = (w_dx < c_spr_dim) && (w_dy < c_spr_dim);

`ifdef SWORD_MIRROR_EN
  localparam logic [c_px_w-1:0] c_px_max = c_px_w'(SPR_DIM - 1);
  assign w_dir_field = (r_dir == DIR_LEFT) ? DIR_RIGHT : r_dir;
  assign w_dx_field  = (r_dir == DIR_LEFT) ? (c_px_max - w_dx[c_px_w-1:0])
                                           : w_dx[c_px_w-1:0];
`else
  assign w_dir_field = r_dir;
  assign w_dx_field  = w_dx[c_px_w-1:0];
`endif

  // Address is one stage behind DrawX/DrawY; sprite_on adds a second stage to
  // line up with the synchronous ROM output.
  always_ff @(posedge vga_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_address <= '0;
      r_on_q1     <= 1'b0;
      sprite_on   <= 1'b0;
    end else begin
      rom_address <= w_in_box ? {w_dir_field, r_frame, w_dy[c_px_w-1:0], w_dx_field} : '0;
      r_on_q1     <= w_in_box && (r_state == ACTIVE);
      sprite_on   <= r_on_q1;
    end
  end

endmodule

`default_nettype wire
